// File: rtl/md5_block_engine.sv
// md5_block_engine: iterative MD5 compression of one 512-bit block, STEPS_PER_CYCLE steps per clock,
// with chaining via h_in and valid/ready handshakes on both sides.
module md5_block_engine #(
    parameter int STEPS_PER_CYCLE = 1,
    parameter bit SWAP_ENDIAN     = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_msg,
    input  logic         in_init,
    input  logic [127:0] h_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_digest,
    output logic         busy
);
    if (STEPS_PER_CYCLE != 1 && STEPS_PER_CYCLE != 2 && STEPS_PER_CYCLE != 4) begin : g_bad_spc
        $error("STEPS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [127:0] IV = 128'h67452301_efcdab89_98badcfe_10325476;
    localparam logic [31:0] K [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };
    // Rotate amounts repeat every four steps within a round: index by {round, step%4}.
    localparam logic [4:0] S_TAB [16] = '{
        5'd7, 5'd12, 5'd17, 5'd22, 5'd5, 5'd9, 5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23, 5'd6, 5'd10, 5'd15, 5'd21
    };

    typedef enum logic [1:0] {IDLE, RUN, FINAL, HOLD} state_t;

    state_t       state_q, state_d;
    logic [5:0]   step_q, step_d;
    logic [127:0] abcd_q, abcd_d;
    logic [127:0] iv_q, iv_d;
    logic [127:0] digest_q, digest_d;
    logic [31:0]  m_q [16];
    logic [31:0]  m_d [16];
    logic [127:0] st;

    function automatic logic [31:0] bsw(input logic [31:0] w);
        return SWAP_ENDIAN ? {w[7:0], w[15:8], w[23:16], w[31:24]} : w;
    endfunction

    function automatic logic [127:0] bsw4(input logic [127:0] x);
        return {bsw(x[127:96]), bsw(x[95:64]), bsw(x[63:32]), bsw(x[31:0])};
    endfunction

    function automatic logic [3:0] msg_idx(input logic [5:0] i);
        logic [3:0] j;
        j = i[3:0];
        return i[5:4] == 2'd0 ? j : i[5:4] == 2'd1 ? j * 4'd5 + 4'd1 : i[5:4] == 2'd2 ? j * 4'd3 + 4'd5 : j * 4'd7;
    endfunction

    function automatic logic [127:0] md5_step(input logic [127:0] s_in, input logic [5:0] i, input logic [31:0] m);
        logic [31:0] a, b, c, d, f, x;
        logic [4:0]  s;
        {a, b, c, d} = s_in;
        f = i[5:4] == 2'd0 ? (b & c) | (~b & d) :
            i[5:4] == 2'd1 ? (d & b) | (~d & c) :
            i[5:4] == 2'd2 ? b ^ c ^ d : c ^ (b | ~d);
        x = a + f + K[i] + m;
        s = S_TAB[{i[5:4], i[1:0]}];
        return {d, b + ((x << s) | (x >> (6'd32 - {1'b0, s}))), b, c};
    endfunction

    always_comb begin
        st = abcd_q;
        for (int k = 0; k < STEPS_PER_CYCLE; k++)
            st = md5_step(st, step_q + 6'(k), m_q[msg_idx(step_q + 6'(k))]);
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        abcd_d   = abcd_q;
        iv_d     = iv_q;
        m_d      = m_q;
        digest_d = digest_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = RUN;
                step_d  = '0;
                for (int j = 0; j < 16; j++) m_d[j] = bsw(in_msg[32*(15-j) +: 32]);
                iv_d    = in_init ? IV : bsw4(h_in);
                abcd_d  = in_init ? IV : bsw4(h_in);
            end
            RUN: begin
                abcd_d  = st;
                step_d  = step_q + 6'(STEPS_PER_CYCLE);
                state_d = step_q == 6'(64 - STEPS_PER_CYCLE) ? FINAL : RUN;
            end
            FINAL: begin
                digest_d = bsw4({iv_q[127:96] + abcd_q[127:96], iv_q[95:64] + abcd_q[95:64],
                                 iv_q[63:32] + abcd_q[63:32], iv_q[31:0] + abcd_q[31:0]});
                state_d  = HOLD;
            end
            HOLD: state_d = out_ready ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            step_q   <= '0;
            abcd_q   <= '0;
            iv_q     <= '0;
            digest_q <= '0;
            m_q      <= '{default: '0};
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            abcd_q   <= abcd_d;
            iv_q     <= iv_d;
            digest_q <= digest_d;
            m_q      <= m_d;
        end
    end

    assign in_ready   = state_q == IDLE;
    assign busy       = state_q != IDLE;
    assign out_valid  = state_q == HOLD;
    assign out_digest = digest_q;
endmodule

// File: tb/tb_md5_block_engine.sv
// tb_md5_block_engine: runs 1/2/4-steps-per-clock engines plus an unswapped one in lockstep
// against known digests and a plain MD5 model (K derived from sin).
module tb_md5_block_engine;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic in_init = 1'b0;
    logic out_ready = 1'b0;
    logic [511:0] msg = '0;
    logic [511:0] msg_ns;
    logic [127:0] h_in = '0;
    logic [127:0] h_ns;
    logic [3:0] rdy, vld, bsy;
    logic [127:0] dig [4];
    logic [31:0] kt [64];
    int checks = 0;
    int failures = 0;
    int lat [4];

    localparam logic [31:0] IVW [4] = '{32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};
    localparam int SH [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

    typedef struct {
        logic [511:0] msg;
        logic         init;
        logic [127:0] h;
        logic [127:0] exp;
    } vec_t;

    always #5 clk = ~clk;

    function automatic logic [31:0] bs(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [127:0] bs4(input logic [127:0] x);
        return {bs(x[127:96]), bs(x[95:64]), bs(x[63:32]), bs(x[31:0])};
    endfunction

    function automatic logic [511:0] bs16(input logic [511:0] x);
        logic [511:0] y;
        for (int j = 0; j < 16; j++) y[32*j +: 32] = bs(x[32*j +: 32]);
        return y;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] y;
        for (int j = 0; j < 16; j++) y[32*j +: 32] = $urandom();
        return y;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic int spc(input int n);
        return n == 2 ? 4 : n == 1 ? 2 : 1;
    endfunction

    // Textbook MD5 compression; h and the result are in the engine's digest byte order.
    function automatic logic [127:0] model(input logic init, input logic [127:0] h, input logic [511:0] blk);
        logic [31:0] x [16];
        logic [31:0] v [4];
        logic [31:0] a, b, c, d, f, r, t;
        int gi, sa;
        for (int j = 0; j < 16; j++) x[j] = bs(blk[32*(15-j) +: 32]);
        for (int j = 0; j < 4; j++) v[j] = init ? IVW[j] : bs(h[32*(3-j) +: 32]);
        a = v[0]; b = v[1]; c = v[2]; d = v[3];
        for (int i = 0; i < 64; i++) begin
            case (i / 16)
                0: begin f = (b & c) | (~b & d); gi = i; end
                1: begin f = (d & b) | (~d & c); gi = (5 * i + 1) % 16; end
                2: begin f = b ^ c ^ d; gi = (3 * i + 5) % 16; end
                default: begin f = c ^ (b | ~d); gi = (7 * i) % 16; end
            endcase
            sa = SH[(i / 16) * 4 + i % 4];
            r = a + f + kt[i] + x[gi];
            t = b + ((r << sa) | (r >> (32 - sa)));
            a = d; d = c; c = b; b = t;
        end
        return {bs(v[0] + a), bs(v[1] + b), bs(v[2] + c), bs(v[3] + d)};
    endfunction

    assign msg_ns = bs16(msg);
    assign h_ns   = bs4(h_in);

    for (genvar g = 0; g < 4; g++) begin : g_dut
        md5_block_engine #(.STEPS_PER_CYCLE(g == 2 ? 4 : g == 1 ? 2 : 1), .SWAP_ENDIAN(g != 3)) u_dut (
            .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[g]),
            .in_msg(g == 3 ? msg_ns : msg), .in_init(in_init), .h_in(g == 3 ? h_ns : h_in),
            .out_valid(vld[g]), .out_ready(out_ready), .out_digest(dig[g]), .busy(bsy[g])
        );
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Offer a block for one accept edge, then scramble the inputs it must no longer depend on.
    task automatic start(input logic [511:0] m, input logic init, input logic [127:0] h);
        @(negedge clk);
        msg = m;
        in_init = init;
        h_in = h;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        msg = rnd512();
        h_in = rnd128();
        in_init = ~init;
    endtask

    task automatic collect(input logic [127:0] e, input string nm);
        lat = '{default: 0};
        for (int c = 1; c <= 80 && vld != 4'hf; c++) begin
            @(posedge clk);
            #1;
            for (int n = 0; n < 4; n++) if (vld[n] && lat[n] == 0) lat[n] = c;
        end
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("%s latency[%0d]", nm, n), 128'(lat[n]), 128'(64 / spc(n) + 1));
            chk($sformatf("%s digest[%0d]", nm, n), dig[n], n == 3 ? bs4(e) : e);
        end
    endtask

    task automatic drain(input string nm);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({nm, " out_valid cleared"}, 128'(vld), 128'h0);
        chk({nm, " in_ready back"}, 128'(rdy), 128'hf);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tv [3];
        logic [511:0] blk1, blk2, rm;
        logic [127:0] h1, rh;
        logic ri;
        int early, late;
        for (int i = 0; i < 64; i++) begin
            real r;
            r = $sin(real'(i + 1));
            if (r < 0.0) r = -r;
            kt[i] = 32'(longint'($floor(r * 4294967296.0)));
        end
        tv[0] = '{msg: {8'h80, 504'h0}, init: 1'b1, h: '0, exp: 128'hd41d8cd98f00b204e9800998ecf8427e};
        tv[1] = '{msg: {32'h61626380, 416'h0, 32'h18000000, 32'h0}, init: 1'b1, h: '0,
                  exp: 128'h900150983cd24fb0d6963f7d28e17f72};
        tv[2] = '{msg: {32'h61800000, 416'h0, 32'h08000000, 32'h0}, init: 1'b1, h: 128'h1234,
                  exp: 128'h0cc175b9c0f1b6a831c399e269772661};
        blk1 = {16{32'h61616161}};
        blk2 = {32'h80000000, 416'h0, 32'h00020000, 32'h0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", 128'(rdy), 128'hf);
        chk("reset out_valid", 128'(vld), 128'h0);
        chk("reset busy", 128'(bsy), 128'h0);
        for (int n = 0; n < 4; n++) chk($sformatf("reset digest[%0d]", n), dig[n], 128'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int t = 0; t < 3; t++) begin
            start(tv[t].msg, tv[t].init, tv[t].h);
            chk($sformatf("vec%0d busy", t), 128'(bsy), 128'hf);
            collect(tv[t].exp, $sformatf("vec%0d", t));
            drain($sformatf("vec%0d", t));
        end

        h1 = model(1'b1, '0, blk1);
        start(blk1, 1'b1, rnd128());
        collect(h1, "chain1");
        drain("chain1");
        start(blk2, 1'b0, h1);
        collect(128'h014842d480b571495a4a0363793f7367, "chain2");
        drain("chain2");

        start(tv[1].msg, 1'b1, '0);
        collect(tv[1].exp, "bp");
        @(negedge clk);
        msg = tv[0].msg;
        in_init = 1'b1;
        in_valid = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("bp in_ready low", 128'(rdy), 128'h0);
            chk("bp out_valid held", 128'(vld), 128'hf);
            for (int n = 0; n < 4; n++) chk($sformatf("bp digest held[%0d]", n), dig[n], n == 3 ? bs4(tv[1].exp) : tv[1].exp);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp release out_valid", 128'(vld), 128'h0);
        chk("bp release in_ready", 128'(rdy), 128'hf);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        msg = rnd512();
        chk("bp second accepted", 128'(bsy), 128'hf);
        collect(tv[0].exp, "bp second");
        drain("bp second");

        early = 0;
        start(tv[0].msg, 1'b1, '0);
        repeat (30) begin
            @(posedge clk);
            #1;
            if (vld[0] || vld[3]) early++;
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset early out_valid", 128'(early), 128'h0);
        chk("midreset in_ready", 128'(rdy), 128'hf);
        chk("midreset out_valid", 128'(vld), 128'h0);
        chk("midreset busy", 128'(bsy), 128'h0);
        for (int n = 0; n < 4; n++) chk($sformatf("midreset digest[%0d]", n), dig[n], 128'h0);
        @(negedge clk);
        reset = 1'b0;
        late = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (vld != 4'h0) late++;
        end
        chk("midreset no output", 128'(late), 128'h0);
        start(tv[1].msg, 1'b1, '0);
        collect(tv[1].exp, "after reset");
        drain("after reset");

        for (int t = 0; t < 250; t++) begin
            rm = rnd512();
            rh = rnd128();
            ri = 1'($urandom_range(0, 1));
            start(rm, ri, rh);
            collect(model(ri, rh, rm), $sformatf("rand%0d", t));
            drain($sformatf("rand%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
